// File: rtl/rx_check_pkg.sv
// Shared types, default parameters and helpers for the RX stream checker.
package rx_check_pkg;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } chk_state_t;

   localparam int DEF_SYM_W       = 2;
   localparam int DEF_WORD_W      = 8;
   localparam int DEF_CNT_W       = 32;
   localparam int DEF_LOCK_WORDS  = 4;
   localparam int DEF_UNLOCK_ERRS = 4;

   // Widest word the popcount helper accepts; callers zero-extend into it.
   localparam int POP_MAX_W = 256;

   // Number of set bits in v.
   function automatic logic [8:0] popcount(input logic [POP_MAX_W-1:0] v);
      logic [8:0] c;
      c = 9'd0;
      for (int i = 0; i < POP_MAX_W; i++) begin
         c = c + {8'd0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/sym_packer.sv
// Packs SYM_W-bit symbols MSB-first into WORD_W-bit words. A slip request
// discards the next accepted symbol so the word boundary moves by one symbol.
module sym_packer
   import rx_check_pkg::*;
#(
   parameter int SYM_W  = DEF_SYM_W,
   parameter int WORD_W = DEF_WORD_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_in_valid,
   input  logic [SYM_W-1:0]  i_in_data,
   input  logic              i_slip,
   output logic [WORD_W-1:0] o_word_q,
   output logic              o_full_q
);

   localparam int PHASES = WORD_W / SYM_W;
   localparam int PH_W   = $clog2(PHASES);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);
   localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

   logic [WORD_W-SYM_W-1:0] r_shift;
   logic [PH_W-1:0]         r_phase;
   logic [WORD_W-1:0]       r_word;
   logic                    r_full;
   logic                    r_slip_pend;
   logic [WORD_W-1:0]       w_next;
   logic                    w_hold;

   // The incoming symbol appended to the symbols already collected.
   assign w_next = {r_shift, i_in_data};
   // A slip raised in the same cycle as a symbol applies to that symbol.
   assign w_hold = r_slip_pend | i_slip;

   // Shift register, phase counter, word capture and pending-slip flag.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_shift     <= '0;
         r_phase     <= '0;
         r_word      <= '0;
         r_full      <= 1'b0;
         r_slip_pend <= 1'b0;
      end else begin
         r_full <= 1'b0;
         if (i_in_valid) begin
            r_shift     <= w_next[WORD_W-SYM_W-1:0];
            r_slip_pend <= 1'b0;
            if (w_hold) begin
               r_phase <= r_phase;
            end else if (r_phase == PH_LAST) begin
               r_word  <= w_next;
               r_full  <= 1'b1;
               r_phase <= '0;
            end else begin
               r_phase <= r_phase + PH_ONE;
            end
         end else begin
            r_slip_pend <= w_hold;
         end
      end
   end

   assign o_word_q = r_word;
   assign o_full_q = r_full;

endmodule

// File: rtl/rx_stream_checker.sv
// Aligns a packed symbol stream to a reference word stream (search/lock FSM)
// and gathers BER statistics while locked.
module rx_stream_checker
   import rx_check_pkg::*;
#(
   parameter int SYM_W       = DEF_SYM_W,
   parameter int WORD_W      = DEF_WORD_W,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int LOCK_WORDS  = DEF_LOCK_WORDS,
   parameter int UNLOCK_ERRS = DEF_UNLOCK_ERRS
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_in_valid,
   input  logic [SYM_W-1:0]  i_in_data,
   input  logic              i_ref_valid,
   input  logic [WORD_W-1:0] i_ref_data,
   output logic              o_ref_ready,
   input  logic              i_clear,
   output logic              o_locked,
   output logic              o_err_pulse,
   output logic [CNT_W-1:0]  o_word_cnt,
   output logic [CNT_W-1:0]  o_err_word_cnt,
   output logic [CNT_W-1:0]  o_bit_err_cnt,
   output logic [CNT_W-1:0]  o_underrun_cnt
);

   localparam int NERR_W = $clog2(WORD_W + 1);
   localparam int RUN_W  = $clog2(LOCK_WORDS + 1);
   localparam int ERUN_W = $clog2(UNLOCK_ERRS + 1);
   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_WORDS - 1);
   localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
   localparam logic [ERUN_W-1:0] ERUN_LAST = ERUN_W'(UNLOCK_ERRS - 1);
   localparam logic [ERUN_W-1:0] ERUN_ONE  = ERUN_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   chk_state_t          r_state;
   logic [RUN_W-1:0]    r_run;
   logic [ERUN_W-1:0]   r_erun;
   logic                r_err_pulse;
   logic [CNT_W-1:0]    r_word_cnt;
   logic [CNT_W-1:0]    r_err_word_cnt;
   logic [CNT_W-1:0]    r_bit_err_cnt;
   logic [CNT_W-1:0]    r_underrun_cnt;

   logic [WORD_W-1:0]   w_word;
   logic                w_full;
   logic [WORD_W-1:0]   w_diff;
   logic                w_match;
   logic [NERR_W-1:0]   w_nerr;
   logic                w_cmp;
   logic                w_underrun;
   logic                w_slip;
   logic                w_err;
   logic                w_locked;
   logic [CNT_W:0]      w_bit_sum;

   sym_packer #(
      .SYM_W  (SYM_W),
      .WORD_W (WORD_W)
   ) u_packer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_in_valid (i_in_valid),
      .i_in_data  (i_in_data),
      .i_slip     (w_slip),
      .o_word_q   (w_word),
      .o_full_q   (w_full)
   );

   assign w_locked   = (r_state == LOCKED);
   assign w_diff     = w_word ^ i_ref_data;
   assign w_match    = (w_diff == '0);
   assign w_nerr     = NERR_W'(popcount(POP_MAX_W'(w_diff)));
   assign w_cmp      = w_full & i_ref_valid;
   assign w_underrun = w_full & ~i_ref_valid;
   // While searching, a mismatching reference word is held and the packer slips.
   assign w_slip     = w_cmp & ~w_locked & ~w_match;
   assign w_err      = w_cmp & w_locked & ~w_match;
   assign w_bit_sum  = {1'b0, r_bit_err_cnt} + {{(CNT_W + 1 - NERR_W){1'b0}}, w_nerr};

   assign o_ref_ready = w_cmp & (w_locked | w_match);

   // Search/lock state machine with match and error run lengths.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= SEARCH;
         r_run   <= '0;
         r_erun  <= '0;
      end else if (w_cmp) begin
         case (r_state)
            SEARCH: begin
               if (!w_match) begin
                  r_run <= '0;
               end else if (r_run == RUN_LAST) begin
                  r_state <= LOCKED;
                  r_run   <= '0;
               end else begin
                  r_run <= r_run + RUN_ONE;
               end
            end
            LOCKED: begin
               if (w_match) begin
                  r_erun <= '0;
               end else if (r_erun == ERUN_LAST) begin
                  r_state <= SEARCH;
                  r_run   <= '0;
                  r_erun  <= '0;
               end else begin
                  r_erun <= r_erun + ERUN_ONE;
               end
            end
            default: begin
               r_state <= SEARCH;
               r_run   <= '0;
               r_erun  <= '0;
            end
         endcase
      end else begin
         r_state <= r_state;
      end
   end

   // Saturating statistics counters; clear overrides a coincident update.
   always_ff @(posedge i_clk) begin
      if (!i_rst || i_clear) begin
         r_word_cnt     <= '0;
         r_err_word_cnt <= '0;
         r_bit_err_cnt  <= '0;
         r_underrun_cnt <= '0;
      end else begin
         if (w_underrun && (r_underrun_cnt != CNT_MAX)) begin
            r_underrun_cnt <= r_underrun_cnt + CNT_ONE;
         end
         if (w_cmp && w_locked && (r_word_cnt != CNT_MAX)) begin
            r_word_cnt <= r_word_cnt + CNT_ONE;
         end
         if (w_err) begin
            if (r_err_word_cnt != CNT_MAX) begin
               r_err_word_cnt <= r_err_word_cnt + CNT_ONE;
            end
            r_bit_err_cnt <= w_bit_sum[CNT_W] ? CNT_MAX : w_bit_sum[CNT_W-1:0];
         end
      end
   end

   // One-cycle pulse per errored word compared while locked.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_err_pulse <= 1'b0;
      end else begin
         r_err_pulse <= w_err;
      end
   end

   assign o_locked       = w_locked;
   assign o_err_pulse    = r_err_pulse;
   assign o_word_cnt     = r_word_cnt;
   assign o_err_word_cnt = r_err_word_cnt;
   assign o_bit_err_cnt  = r_bit_err_cnt;
   assign o_underrun_cnt = r_underrun_cnt;

endmodule

// File: doc/rx_stream_checker.md
# rx_stream_checker

Synthesizable, parametrised successor to the RX-path bench checker. It packs the demodulator's symbol stream into words MSB-first and aligns itself to a reference word stream with a search/lock state machine. Once locked it compares every word against the reference, counting words, errored words, bit errors and reference underruns. It sits after `RX_path_top` on-chip, and in benches, for BER measurement; the reference stream comes from a PRBS generator or a file source.

## Interface
- `SYM_W`, 2: bits per input symbol.
- `WORD_W`, 8: packed word width; must be a multiple of `SYM_W`, with `WORD_W/SYM_W` ≥ 2.
- `CNT_W`, 32: width of the statistics counters.
- `LOCK_WORDS`, 4: consecutive matching words needed to enter LOCKED.
- `UNLOCK_ERRS`, 4: consecutive errored words that force a return to SEARCH.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `in_valid` in 1: symbol strobe from the RX path. There is no backpressure.
- `in_data` in `SYM_W`: symbol value.
- `ref_valid` in 1: reference word available.
- `ref_data` in `WORD_W`: reference word.
- `ref_ready` out 1: reference word consumed this cycle.
- `clear` in 1: synchronous clear of the statistics counters.
- `locked` out 1: high while the state is LOCKED.
- `err_pulse` out 1: one-cycle pulse per errored word compared in LOCKED.
- `word_cnt` out `CNT_W`: words compared while LOCKED.
- `err_word_cnt` out `CNT_W`: errored words compared while LOCKED.
- `bit_err_cnt` out `CNT_W`: total differing bits while LOCKED.
- `underrun_cnt` out `CNT_W`: completed words that found `ref_valid` low.

## Operation
- **Packer.**
  - On each `in_valid`, `shift <= {shift[WORD_W-SYM_W-1:0], in_data}` and the phase counter increments.
  - At the last phase the completed word is copied to `word_q`, `full_q` is set for exactly one cycle, and the phase wraps to 0.
  - Symbols arriving back-to-back are never lost.
- **Compare cycle** (`full_q` high):
  - `match = (word_q == ref_data)`.
  - `nerr = popcount(word_q ^ ref_data)`; this value is `$clog2(WORD_W+1)` bits wide.
- **SEARCH** (state after reset):
  - `full_q & !ref_valid`: underrun. `underrun_cnt++`, the word is dropped, no slip.
  - `full_q & ref_valid & match`: `ref_ready=1`, `run++`. When `run` reaches `LOCK_WORDS`, go to LOCKED, `run<=0`.
  - `full_q & ref_valid & !match`: `ref_ready=0` (the reference word is held) and `run<=0`. Slip: the phase counter holds for one `in_valid`, which discards one symbol, so the next word boundary shifts by one symbol.
  - Statistics other than `underrun_cnt` do not change.
- **LOCKED:**
  - `full_q & !ref_valid`: `underrun_cnt++`, the word is dropped, error counters are unchanged.
  - `full_q & ref_valid`: `ref_ready=1`, `word_cnt++`.
  - On a mismatch additionally: `err_word_cnt++`, `bit_err_cnt += nerr`, `err_pulse`, `erun++`.
  - On a match: `erun<=0`.
  - When `erun` reaches `UNLOCK_ERRS`, go to SEARCH with `run` and `erun` at 0.
- All counters saturate at all-ones.
- `clear`:
  - Zeroes the four statistics counters only. The FSM and packer are unaffected.
  - If a compare coincides with `clear`, `clear` wins (the counters read 0 afterwards).

## Timing
- Reset values:
  - All outputs are 0.
  - State is SEARCH; phase, `run`, `erun` and `full_q` are 0.
- `ref_ready` is combinational from `full_q`, state, `ref_valid` and the compare result, and is asserted only in the `full_q` cycle.
- Latency:
  - Last symbol of a word at edge N.
  - `full_q` and the compare during cycle N+1.
  - Counters, `err_pulse` and `locked` updated at edge N+2.
- `locked` rises in the cycle after the `LOCK_WORDS`-th match and falls in the cycle after the `UNLOCK_ERRS`-th consecutive error.
- A `rst` low mid-word discards the partial word, drops `full_q` and returns to SEARCH on the next edge.

## Structure
- Package `rx_check_pkg`:
  - `typedef enum logic {SEARCH, LOCKED} chk_state_t`.
  - A popcount function.
  - Default parameter constants.
- One sub-module, `sym_packer` (`SYM_W`, `WORD_W`; inputs `in_valid`, `in_data`, `slip`; outputs `word_q`, `full_q`), which owns the phase counter and slip logic.

## Test plan
- **Aligned lock.** `SYM_W=2`, `WORD_W=8`; the reference is bytes 0x00..0xFF and the input is the same bytes as MSB-first 2-bit symbols starting on a word boundary. Required: `locked` rises after the 4th byte, `word_cnt` = 252 at the end, all error counters 0.
- **Misalignment.** The same stream preceded by 1 extra symbol. Required: the packer slips, lock is reached within `WORD_W/SYM_W`+`LOCK_WORDS` words, and no error counts before lock.
- **Injected errors.** Once locked, flip 3 bits in one byte and 1 bit in another. Required: `err_word_cnt`=2, `bit_err_cnt`=4, 2 `err_pulse`s, `locked` stays 1.
- **Loss of lock.** Corrupt 4 consecutive bytes. Required: `locked` falls at the cycle after the 4th compare, `ref_ready` stays low on subsequent mismatches, and lock is regained after 4 clean matches.
- **Underrun.** Hold `ref_valid` low across 2 word completions while locked. Required: `underrun_cnt`=2, `word_cnt` and the error counters unchanged.
- **`clear` and reset.** Assert `clear` together with an errored compare. Required: all counters read 0 and `locked` is unchanged. Then pull `rst` low mid-word. Required: all outputs 0 on the next edge, and after release the partial word is not counted.
